// File: rtl/sf_pkt_ctrl.sv
// Store-and-forward packet controller: pointer, commit and packet-count logic.
// Optional bad/truncated packet discard enabled by SF_PKT_CTRL_DROP_EN.
module sf_pkt_ctrl #(
   parameter int DEPTH_LG2  = 4,
   parameter int DATA_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 wren_i,
   input  logic [DATA_WIDTH-1:0] wdata_i,
   output logic                 wready_o,
   output logic                 mem_we_o,
   output logic [DEPTH_LG2-1:0] mem_waddr_o,
   input  logic                 rden_i,
   output logic                 mem_re_o,
   output logic [DEPTH_LG2-1:0] mem_raddr_o,
   output logic                 rvalid_o,
   output logic                 rlast_o,
   output logic                 pkt_avail_o,
   output logic [DEPTH_LG2:0]   pkt_cnt_o,
   output logic                 drop_o,
   output logic                 ovf_o
);

   localparam int DEPTH = 2 ** DEPTH_LG2;
   localparam int PW    = DEPTH_LG2 + 1;
   localparam logic [PW-1:0] DEPTH_P = PW'(DEPTH);
   localparam logic [PW-1:0] ONE_P   = PW'(1);

   logic [PW-1:0]    wptr_q, wptr_d;
   logic [PW-1:0]    cwptr_q, cwptr_d;
   logic [PW-1:0]    rptr_q, rptr_d;
   logic [PW-1:0]    pkt_cnt_q, pkt_cnt_d;
   logic [DEPTH-1:0] eop_q, eop_d;
   logic             trunc_q, trunc_d;
   logic             rvalid_q, rvalid_d;
   logic             rlast_q, rlast_d;
   logic             ovf_q, ovf_d;

   logic [PW-1:0]    used;
   logic             full;
   logic             wr_acc;
   logic             rd_acc;
   logic             is_eop;
   logic             eop_rd;
   logic             commit;

   assign used     = wptr_q - rptr_q;
   assign full     = (used == DEPTH_P);
   assign is_eop   = (wdata_i[DATA_WIDTH-1:1] == '0);
   assign wr_acc   = wren_i & ~full;
   assign rd_acc   = rden_i & pkt_avail_o;
   assign eop_rd   = rd_acc & eop_q[rptr_q[DEPTH_LG2-1:0]];

   assign wready_o    = ~full;
   assign mem_we_o    = wr_acc;
   assign mem_waddr_o = wptr_q[DEPTH_LG2-1:0];
   assign mem_re_o    = rd_acc;
   assign mem_raddr_o = rptr_q[DEPTH_LG2-1:0];
   assign rvalid_o    = rvalid_q;
   assign rlast_o     = rlast_q;
   assign pkt_cnt_o   = pkt_cnt_q;
   assign pkt_avail_o = (pkt_cnt_q != '0);
   assign ovf_o       = ovf_q;

`ifdef SF_PKT_CTRL_DROP_EN
   logic drop_q, drop_d;
   logic is_err;

   assign is_err = wdata_i[0];
   assign drop_o = drop_q;

   always_comb begin
      drop_d  = 1'b0;
      commit  = 1'b0;
      trunc_d = trunc_q;
      wptr_d  = wptr_q;
      cwptr_d = cwptr_q;
      eop_d   = eop_q;
      if (wr_acc) begin
         eop_d[wptr_q[DEPTH_LG2-1:0]] = is_eop;
         wptr_d = wptr_q + ONE_P;
         if (is_eop) begin
            trunc_d = 1'b0;
            if (is_err | trunc_q) drop_d = 1'b1;
            else commit = 1'b1;
         end
      end else if (wren_i) begin
         trunc_d = 1'b1;
         // an EOP arriving while full ends a packet that can never fit
         if (is_eop) begin
            drop_d  = 1'b1;
            trunc_d = 1'b0;
         end
      end
      if (commit) cwptr_d = wptr_q + ONE_P;
      if (drop_d) wptr_d = cwptr_q;
   end
`else
   logic unused_err;

   assign unused_err = wdata_i[0];
   assign drop_o     = 1'b0;

   always_comb begin
      commit  = 1'b0;
      trunc_d = trunc_q;
      wptr_d  = wptr_q;
      cwptr_d = cwptr_q;
      eop_d   = eop_q;
      if (wr_acc) begin
         eop_d[wptr_q[DEPTH_LG2-1:0]] = is_eop;
         wptr_d = wptr_q + ONE_P;
         if (is_eop) begin
            trunc_d = 1'b0;
            commit  = 1'b1;
         end
      end else if (wren_i) begin
         trunc_d = 1'b1;
      end
      if (commit) cwptr_d = wptr_q + ONE_P;
   end
`endif

   always_comb begin
      rptr_d    = rptr_q + PW'(rd_acc);
      rvalid_d  = rd_acc;
      rlast_d   = eop_rd;
      ovf_d     = wren_i & full;
      pkt_cnt_d = pkt_cnt_q + PW'(commit) - PW'(eop_rd);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wptr_q    <= '0;
         cwptr_q   <= '0;
         rptr_q    <= '0;
         pkt_cnt_q <= '0;
         eop_q     <= '0;
         trunc_q   <= 1'b0;
         rvalid_q  <= 1'b0;
         rlast_q   <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         wptr_q    <= wptr_d;
         cwptr_q   <= cwptr_d;
         rptr_q    <= rptr_d;
         pkt_cnt_q <= pkt_cnt_d;
         eop_q     <= eop_d;
         trunc_q   <= trunc_d;
         rvalid_q  <= rvalid_d;
         rlast_q   <= rlast_d;
         ovf_q     <= ovf_d;
      end
   end

`ifdef SF_PKT_CTRL_DROP_EN
   always_ff @(posedge clk) begin
      if (!rst_n) drop_q <= 1'b0;
      else drop_q <= drop_d;
   end
`endif

endmodule

// File: tb/tb_sf_pkt_ctrl.sv
// Randomized bench for sf_pkt_ctrl against a packet-level reference model.
// Directed scenarios cover commit, drop, full/overflow, reset and wrap.
module tb_sf_pkt_ctrl;

   localparam int LG = 4;
   localparam int DW = 32;
   localparam int D  = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          wren_i = 1'b0;
   logic [DW-1:0] wdata_i = '0;
   logic          rden_i = 1'b0;
   logic          wready_o, mem_we_o, mem_re_o;
   logic [LG-1:0] mem_waddr_o, mem_raddr_o;
   logic          rvalid_o, rlast_o, pkt_avail_o, drop_o, ovf_o;
   logic [LG:0]   pkt_cnt_o;

   int n_tests = 0;
   int n_fail  = 0;

   // model: absolute (unwrapped) pointers and per-slot EOP flags
   int m_wp, m_cwp, m_rp, m_cnt;
   bit m_trunc;
   bit m_eop[D];
   bit x_rvalid, x_rlast, x_drop, x_ovf;

   sf_pkt_ctrl #(.DEPTH_LG2(LG), .DATA_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n),
      .wren_i(wren_i), .wdata_i(wdata_i), .wready_o(wready_o),
      .mem_we_o(mem_we_o), .mem_waddr_o(mem_waddr_o),
      .rden_i(rden_i), .mem_re_o(mem_re_o), .mem_raddr_o(mem_raddr_o),
      .rvalid_o(rvalid_o), .rlast_o(rlast_o),
      .pkt_avail_o(pkt_avail_o), .pkt_cnt_o(pkt_cnt_o),
      .drop_o(drop_o), .ovf_o(ovf_o)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_wp = 0; m_cwp = 0; m_rp = 0; m_cnt = 0;
      m_trunc = 1'b0;
      x_rvalid = 1'b0; x_rlast = 1'b0; x_drop = 1'b0; x_ovf = 1'b0;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; wren_i = 1'b0; rden_i = 1'b0; wdata_i = '0;
      @(posedge clk);
      model_reset();
      #1 rst_n = 1'b1;
   endtask

   task automatic step(bit w, logic [DW-1:0] d, bit r);
      bit full, eop, wacc, racc;
      @(negedge clk);
      wren_i = w; wdata_i = d; rden_i = r;
      #1;
      full = ((m_wp - m_rp) == D);
      eop  = ((d >> 1) == 0);
      wacc = w && !full;
      racc = r && (m_cnt > 0);
      chk("wready", wready_o, !full);
      chk("pkt_cnt", pkt_cnt_o, m_cnt);
      chk("pkt_avail", pkt_avail_o, m_cnt != 0);
      chk("mem_we", mem_we_o, wacc);
      if (wacc) chk("waddr", mem_waddr_o, m_wp % D);
      chk("mem_re", mem_re_o, racc);
      if (racc) chk("raddr", mem_raddr_o, m_rp % D);
      chk("rvalid", rvalid_o, x_rvalid);
      chk("rlast", rlast_o, x_rlast);
      chk("drop", drop_o, x_drop);
      chk("ovf", ovf_o, x_ovf);

      x_rvalid = racc;
      x_rlast  = racc && m_eop[m_rp % D];
      x_ovf    = w && full;
      x_drop   = 1'b0;
      if (racc) begin
         if (m_eop[m_rp % D]) m_cnt--;
         m_rp++;
      end
      if (wacc) begin
         m_eop[m_wp % D] = eop;
         m_wp++;
         if (eop) begin
`ifdef SF_PKT_CTRL_DROP_EN
            if (d[0] || m_trunc) begin
               m_wp = m_cwp;
               x_drop = 1'b1;
            end else begin
               m_cwp = m_wp;
               m_cnt++;
            end
`else
            m_cwp = m_wp;
            m_cnt++;
`endif
            m_trunc = 1'b0;
         end
      end else if (w) begin
         m_trunc = 1'b1;
`ifdef SF_PKT_CTRL_DROP_EN
         if (eop) begin
            m_wp = m_cwp;
            x_drop = 1'b1;
            m_trunc = 1'b0;
         end
`endif
      end
      @(posedge clk);
   endtask

   initial begin
      model_reset();
      do_reset();
      step(0, 0, 0);
      step(0, 0, 1);

      // good 3-word packet, then read it out
      step(1, 32'hA, 0);
      step(1, 32'hB, 0);
      step(1, 32'h0, 0);
      step(0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 1);
      step(0, 0, 0);

      // errored packet followed by a good one
      step(1, 32'h5, 0);
      step(1, 32'h1, 0);
      step(1, 32'h7, 0);
      step(1, 32'h0, 0);
      step(0, 0, 0);
      for (int i = 0; i < 4; i++) step(0, 0, 1);
      step(0, 0, 0);

      // fill without EOP, overflow, then EOP while full
      do_reset();
      for (int i = 0; i < D; i++) step(1, 32'h2 + i, 0);
      step(1, 32'h55, 0);
      step(1, 32'h0, 0);
      step(0, 0, 0);
      step(1, 32'h9, 0);
      step(0, 0, 0);

      // commit and EOP read in the same cycle
      do_reset();
      step(1, 32'h0, 0);
      step(1, 32'h3, 0);
      step(1, 32'h0, 1);
      step(0, 0, 0);
      step(0, 0, 1);
      step(0, 0, 1);
      step(0, 0, 0);

      // reset mid-packet with two packets stored
      step(1, 32'h0, 0);
      step(1, 32'h0, 0);
      step(1, 32'h7, 0);
      do_reset();
      step(0, 0, 0);
      step(0, 0, 1);

      // pointer wrap with single-word packets
      step(1, 32'h0, 0);
      for (int i = 1; i < 40; i++) step(1, 32'h0, 1);
      step(0, 0, 1);
      step(0, 0, 0);

      // random traffic
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         logic [DW-1:0] d;
         if (n % 500 == 499) do_reset();
         case ($urandom % 4)
            0: d = 32'h0;
            1: d = 32'h1;
            default: d = $urandom | 32'h2;
         endcase
         step(bit'($urandom % 2), d, ($urandom % 5) < 2);
      end
      step(0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
